control_unit: RTL and testbench
===============================

# control_unit

Sequencing control unit of the processing core: the consumer side of the instruction register. It drives `load_RI` to capture each fetched instruction word, then reads back `code_op` to run the matching execute sequence. While doing so it strobes the program counter, accumulator, carry flag and data-memory controls. It is a single Moore FSM plus a retired-instruction counter, and sits between the instruction register and the datapath/memory.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `ce` in 1: clock enable; when 0, the FSM and counter hold and all strobes are 0.
- `code_op` in 3: opcode from the instruction register.
- `carry` in 1: carry flag from the datapath.
- `load_RI` out 1: instruction register load strobe.
- `init_PC` out 1: clear the PC.
- `inc_PC` out 1: increment the PC.
- `load_PC` out 1: load the PC from `ADR_RI`.
- `load_ACC` out 1: accumulator load strobe.
- `sel_UAL` out 2: ALU function. 00 = NOR, 01 = ADD, 10 = AND, 11 = PASS (memory operand).
- `load_carry` out 1: capture the ALU carry.
- `init_carry` out 1: clear the carry.
- `en_mem` out 1: memory access enable.
- `we_mem` out 1: memory write enable.
- `sel_ADR` out 1: memory address select. 0 = PC, 1 = `ADR_RI`.
- `halted` out 1: high in HALT.
- `instr_count` out `CNT_W`: number of retired instructions.

## Operation
- Opcodes:
  - 000 NOR: ALU op.
  - 001 ADD: ALU op; updates carry.
  - 010 STA: store accumulator.
  - 011 JCC: jump if carry = 0; always clears carry.
  - 100 AND: ALU op.
  - 101 LDA: ALU op (PASS).
  - 110 JMP: unconditional jump.
  - 111 HLT: halt.
- States and outputs (Moore). Any strobe not listed for a state is 0.
  - INIT: `init_PC` = `init_carry` = 1. Next: FETCH_INS.
  - FETCH_INS: `en_mem` = 1, `sel_ADR` = 0. Next: LOAD_INS.
  - LOAD_INS: `load_RI` = 1, `inc_PC` = 1. Next: DECODE.
  - DECODE: no strobes. Next by `code_op`:
    - NOR/ADD/AND/LDA → FETCH_OP.
    - STA → STORE.
    - JCC/JMP → JUMP.
    - HLT → HALT.
  - FETCH_OP: `en_mem` = 1, `sel_ADR` = 1. Next: EXE_UAL.
  - EXE_UAL: `load_ACC` = 1; `sel_UAL` per opcode; `load_carry` = 1 only for ADD. Next: FETCH_INS.
  - STORE: `en_mem` = `we_mem` = 1, `sel_ADR` = 1. Next: FETCH_INS.
  - JUMP: `load_PC` = (JMP) or (JCC and `carry` = 0); `init_carry` = 1 for JCC. Next: FETCH_INS.
  - HALT: `halted` = 1; no other strobes. Terminal; only reset exits.
- `sel_UAL` is 00 in every state except EXE_UAL.
- `instr_count` increments (mod 2^`CNT_W`, wraps to 0) on the edge leaving EXE_UAL, STORE or JUMP, and on entry to HALT.
- Every strobe output is the state decode ANDed with `ce`. With `ce` = 0 no strobe is asserted, the state holds and the counter holds.
  - `halted` is not gated by `ce`.

## Timing
- Reset (`rst` = 0): state = INIT, `instr_count` = 0, all strobes 0, `halted` = 0, immediately and asynchronously.
  - INIT strobes assert from the first cycle after `rst` rises, while `ce` = 1.
- Reset mid-instruction aborts the sequence at once; no partial strobe is emitted after `rst` falls.
- Memory read latency is 1 cycle: the address is presented in FETCH_INS/FETCH_OP, and data is consumed in LOAD_INS/EXE_UAL.
- `code_op` is sampled only in DECODE and JUMP, after the RI load edge at the end of LOAD_INS.
- `carry` is sampled in JUMP only.
- Cycles per instruction (with `ce` = 1):
  - NOR/ADD/AND/LDA: 5.
  - STA: 4.
  - JCC/JMP: 4.
  - HLT: 3 cycles to reach HALT.
- `ce` low for N cycles stretches the current state by exactly N cycles. The strobe is re-issued once `ce` returns high.
- An opcode change on `code_op` outside DECODE/JUMP has no effect.

## Test plan
- Reset then ADD:
  - Stimulus: release `rst`, `ce` = 1, `code_op` = 001.
  - INIT is one cycle with `init_PC` = `init_carry` = 1.
  - Then `en_mem` = 1/`sel_ADR` = 0, then `load_RI` = `inc_PC` = 1, then idle, then `en_mem` = `sel_ADR` = 1.
  - Then `load_ACC` = `load_carry` = 1 with `sel_UAL` = 01.
  - `instr_count` = 1 after cycle 6.
- JCC:
  - With `carry` = 0: JUMP asserts `load_PC` = 1 and `init_carry` = 1.
  - With `carry` = 1: JUMP asserts `load_PC` = 0 and `init_carry` = 1.
  - Each takes 4 cycles.
- STA:
  - STORE asserts `en_mem` = `we_mem` = `sel_ADR` = 1 for exactly one cycle.
  - `load_ACC` is never asserted during the instruction.
- `ce` stall:
  - Drop `ce` for 3 cycles during FETCH_OP.
  - No strobes during the stall; the FETCH_OP strobes resume afterwards.
  - The instruction completes in 8 cycles; `instr_count` holds during the stall.
- HLT and reset:
  - `code_op` = 111: `halted` = 1 from the 4th cycle and all strobes stay 0 for 20 cycles.
  - Assert `rst` = 0 in HALT: `halted` = 0 and `instr_count` = 0 immediately.
  - Reset in EXE_UAL: `load_ACC` drops the same cycle.
- Counter wrap: with `CNT_W` = 4, 16 LDA instructions → `instr_count` returns to 0.

Source files
------------

// File: rtl/control_unit.sv
// Sequencing control unit: a Moore FSM that fetches and decodes each instruction and
// drives the PC, accumulator, carry and memory strobes. It also counts retired instructions.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [2:0]       code_op,
  input  logic             carry,
  output logic             load_RI,
  output logic             init_PC,
  output logic             inc_PC,
  output logic             load_PC,
  output logic             load_ACC,
  output logic [1:0]       sel_UAL,
  output logic             load_carry,
  output logic             init_carry,
  output logic             en_mem,
  output logic             we_mem,
  output logic             sel_ADR,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    INIT, FETCH_INS, LOAD_INS, DECODE, FETCH_OP, EXE_UAL, STORE, JUMP, HALT
  } state_t;

  localparam logic [2:0] OP_NOR = 3'b000, OP_ADD = 3'b001, OP_STA = 3'b010, OP_JCC = 3'b011,
                         OP_AND = 3'b100, OP_LDA = 3'b101, OP_JMP = 3'b110, OP_HLT = 3'b111;

  // Bit positions in the strobe vector
  localparam int B_LOAD_RI = 0, B_INIT_PC = 1, B_INC_PC = 2, B_LOAD_PC = 3, B_LOAD_ACC = 4,
                 B_SEL0 = 5, B_SEL1 = 6, B_LOAD_CARRY = 7, B_INIT_CARRY = 8, B_EN_MEM = 9,
                 B_WE_MEM = 10, B_SEL_ADR = 11, NSTR = 12;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              retire;
  logic [NSTR-1:0]   strobe_raw;
  logic [NSTR-1:0]   strobe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= INIT;
      op_reg    <= OP_NOR;
      count_reg <= '0;
    end else if (ce) begin
      state_reg <= state_next;
      // The opcode is captured in DECODE so EXE_UAL ignores later changes on code_op
      if (state_reg == DECODE) op_reg <= code_op;
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    strobe_raw = '0;
    retire     = 1'b0;
    case (state_reg)
      INIT: begin
        strobe_raw[B_INIT_PC]    = 1'b1;
        strobe_raw[B_INIT_CARRY] = 1'b1;
        state_next               = FETCH_INS;
      end
      FETCH_INS: begin
        strobe_raw[B_EN_MEM] = 1'b1;
        state_next           = LOAD_INS;
      end
      LOAD_INS: begin
        strobe_raw[B_LOAD_RI] = 1'b1;
        strobe_raw[B_INC_PC]  = 1'b1;
        state_next            = DECODE;
      end
      DECODE: begin
        case (code_op)
          OP_STA:         state_next = STORE;
          OP_JCC, OP_JMP: state_next = JUMP;
          OP_HLT: begin
            state_next = HALT;
            retire     = 1'b1;
          end
          default:        state_next = FETCH_OP;
        endcase
      end
      FETCH_OP: begin
        strobe_raw[B_EN_MEM]  = 1'b1;
        strobe_raw[B_SEL_ADR] = 1'b1;
        state_next            = EXE_UAL;
      end
      EXE_UAL: begin
        strobe_raw[B_LOAD_ACC] = 1'b1;
        case (op_reg)
          OP_ADD: begin
            strobe_raw[B_SEL0]       = 1'b1;
            strobe_raw[B_LOAD_CARRY] = 1'b1;
          end
          OP_AND:  strobe_raw[B_SEL1] = 1'b1;
          OP_LDA: begin
            strobe_raw[B_SEL0] = 1'b1;
            strobe_raw[B_SEL1] = 1'b1;
          end
          default: ;
        endcase
        retire     = 1'b1;
        state_next = FETCH_INS;
      end
      STORE: begin
        strobe_raw[B_EN_MEM]  = 1'b1;
        strobe_raw[B_WE_MEM]  = 1'b1;
        strobe_raw[B_SEL_ADR] = 1'b1;
        retire                = 1'b1;
        state_next            = FETCH_INS;
      end
      JUMP: begin
        strobe_raw[B_LOAD_PC]    = (code_op == OP_JMP) || ((code_op == OP_JCC) && !carry);
        strobe_raw[B_INIT_CARRY] = (code_op == OP_JCC);
        retire                   = 1'b1;
        state_next               = FETCH_INS;
      end
      HALT:    state_next = HALT;
      default: state_next = INIT;
    endcase
  end

  // Gating with rst keeps the INIT strobes quiet while reset is held
  genvar gi;
  generate
    for (gi = 0; gi < NSTR; gi++) begin : g_gate
      assign strobe[gi] = strobe_raw[gi] & ce & rst;
    end
  endgenerate

  assign load_RI     = strobe[B_LOAD_RI];
  assign init_PC     = strobe[B_INIT_PC];
  assign inc_PC      = strobe[B_INC_PC];
  assign load_PC     = strobe[B_LOAD_PC];
  assign load_ACC    = strobe[B_LOAD_ACC];
  assign sel_UAL     = {strobe[B_SEL1], strobe[B_SEL0]};
  assign load_carry  = strobe[B_LOAD_CARRY];
  assign init_carry  = strobe[B_INIT_CARRY];
  assign en_mem      = strobe[B_EN_MEM];
  assign we_mem      = strobe[B_WE_MEM];
  assign sel_ADR     = strobe[B_SEL_ADR];
  assign halted      = (state_reg == HALT);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-cycle vector table plus hand-written
// sequences for halt, asynchronous reset and counter wrap.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic [2:0] code_op = 3'b000;
  logic       carry = 1'b0;

  logic load_RI, init_PC, inc_PC, load_PC, load_ACC, load_carry, init_carry;
  logic en_mem, we_mem, sel_ADR, halted;
  logic [1:0]  sel_UAL;
  logic [15:0] instr_count;

  logic w_load_RI, w_init_PC, w_inc_PC, w_load_PC, w_load_ACC, w_load_carry, w_init_carry;
  logic w_en_mem, w_we_mem, w_sel_ADR, w_halted;
  logic [1:0] w_sel_UAL;
  logic [3:0] w_instr_count;

  always #5 clk = ~clk;

  control_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .code_op(code_op), .carry(carry),
    .load_RI(load_RI), .init_PC(init_PC), .inc_PC(inc_PC), .load_PC(load_PC),
    .load_ACC(load_ACC), .sel_UAL(sel_UAL), .load_carry(load_carry),
    .init_carry(init_carry), .en_mem(en_mem), .we_mem(we_mem), .sel_ADR(sel_ADR),
    .halted(halted), .instr_count(instr_count)
  );

  control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .code_op(code_op), .carry(carry),
    .load_RI(w_load_RI), .init_PC(w_init_PC), .inc_PC(w_inc_PC), .load_PC(w_load_PC),
    .load_ACC(w_load_ACC), .sel_UAL(w_sel_UAL), .load_carry(w_load_carry),
    .init_carry(w_init_carry), .en_mem(w_en_mem), .we_mem(w_we_mem), .sel_ADR(w_sel_ADR),
    .halted(w_halted), .instr_count(w_instr_count)
  );

  // {load_RI, init_PC, inc_PC, load_PC, load_ACC, sel_UAL[1:0], load_carry, init_carry,
  //  en_mem, we_mem, sel_ADR, halted}
  wire [12:0] outs  = {load_RI, init_PC, inc_PC, load_PC, load_ACC, sel_UAL, load_carry,
                       init_carry, en_mem, we_mem, sel_ADR, halted};
  wire [12:0] outs4 = {w_load_RI, w_init_PC, w_inc_PC, w_load_PC, w_load_ACC, w_sel_UAL,
                       w_load_carry, w_init_carry, w_en_mem, w_we_mem, w_sel_ADR, w_halted};

  localparam logic [12:0] ZERO    = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] S_INIT  = 13'b0_1_0_0_0_00_0_1_0_0_0_0;
  localparam logic [12:0] S_FETCH = 13'b0_0_0_0_0_00_0_0_1_0_0_0;
  localparam logic [12:0] S_LOAD  = 13'b1_0_1_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] S_FOP   = 13'b0_0_0_0_0_00_0_0_1_0_1_0;
  localparam logic [12:0] S_ADD   = 13'b0_0_0_0_1_01_1_0_0_0_0_0;
  localparam logic [12:0] S_AND   = 13'b0_0_0_0_1_10_0_0_0_0_0_0;
  localparam logic [12:0] S_LDA   = 13'b0_0_0_0_1_11_0_0_0_0_0_0;
  localparam logic [12:0] S_STORE = 13'b0_0_0_0_0_00_0_0_1_1_1_0;
  localparam logic [12:0] S_JCC_T = 13'b0_0_0_1_0_00_0_1_0_0_0_0;
  localparam logic [12:0] S_JCC_N = 13'b0_0_0_0_0_00_0_1_0_0_0_0;
  localparam logic [12:0] S_JMP   = 13'b0_0_0_1_0_00_0_0_0_0_0_0;
  localparam logic [12:0] S_HALT  = 13'b0_0_0_0_0_00_0_0_0_0_0_1;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [2:0]  op;
    logic        carry;
    logic [12:0] exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic v(input logic r, input logic c, input logic [2:0] op, input logic cy,
                   input logic [12:0] exp, input logic [15:0] cnt);
    vq.push_back('{rst: r, ce: c, op: op, carry: cy, exp: exp, cnt: cnt});
  endtask

  task automatic chk13(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // Reset, then ADD
    v(0,1,3'b001,0,ZERO,0);
    v(1,1,3'b001,0,S_INIT,0);
    v(1,1,3'b001,0,S_FETCH,0);
    v(1,1,3'b001,0,S_LOAD,0);
    v(1,1,3'b001,0,ZERO,0);
    v(1,1,3'b001,0,S_FOP,0);
    v(1,1,3'b001,0,S_ADD,0);
    // JCC, carry = 0: jump taken
    v(1,1,3'b011,0,S_FETCH,1);
    v(1,1,3'b011,0,S_LOAD,1);
    v(1,1,3'b011,0,ZERO,1);
    v(1,1,3'b011,0,S_JCC_T,1);
    // JCC, carry = 1: not taken, carry still cleared
    v(1,1,3'b011,1,S_FETCH,2);
    v(1,1,3'b011,1,S_LOAD,2);
    v(1,1,3'b011,1,ZERO,2);
    v(1,1,3'b011,1,S_JCC_N,2);
    // STA
    v(1,1,3'b010,0,S_FETCH,3);
    v(1,1,3'b010,0,S_LOAD,3);
    v(1,1,3'b010,0,ZERO,3);
    v(1,1,3'b010,0,S_STORE,3);
    // JMP ignores carry
    v(1,1,3'b110,1,S_FETCH,4);
    v(1,1,3'b110,1,S_LOAD,4);
    v(1,1,3'b110,1,ZERO,4);
    v(1,1,3'b110,1,S_JMP,4);
    // AND, opcode changed to ADD after DECODE must not matter
    v(1,1,3'b100,0,S_FETCH,5);
    v(1,1,3'b100,0,S_LOAD,5);
    v(1,1,3'b100,0,ZERO,5);
    v(1,1,3'b001,0,S_FOP,5);
    v(1,1,3'b001,0,S_AND,5);
    // LDA with a 3-cycle ce stall in FETCH_OP (8 cycles total)
    v(1,1,3'b101,0,S_FETCH,6);
    v(1,1,3'b101,0,S_LOAD,6);
    v(1,1,3'b101,0,ZERO,6);
    v(1,0,3'b101,0,ZERO,6);
    v(1,0,3'b101,0,ZERO,6);
    v(1,0,3'b101,0,ZERO,6);
    v(1,1,3'b101,0,S_FOP,6);
    v(1,1,3'b101,0,S_LDA,6);
    // HLT: halted on the 4th cycle of the instruction
    v(1,1,3'b111,0,S_FETCH,7);
    v(1,1,3'b111,0,S_LOAD,7);
    v(1,1,3'b111,0,ZERO,7);
    v(1,1,3'b111,0,S_HALT,8);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      rst = vq[i].rst; ce = vq[i].ce; code_op = vq[i].op; carry = vq[i].carry;
      @(negedge clk);
      chk13($sformatf("vec%0d outs", i), outs, vq[i].exp);
      chk13($sformatf("vec%0d outs_w4", i), outs4, vq[i].exp);
      chk16($sformatf("vec%0d count", i), instr_count, vq[i].cnt);
      chk16($sformatf("vec%0d count_w4", i), {12'd0, w_instr_count}, {12'd0, vq[i].cnt[3:0]});
    end

    // Terminal HALT: 20 cycles, changing opcode and ce has no effect
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      code_op = 3'($urandom_range(0, 7));
      ce = (i != 5);
      @(negedge clk);
      chk13($sformatf("halt%0d outs", i), outs, S_HALT);
      chk16($sformatf("halt%0d count", i), instr_count, 16'd8);
    end
    $display("halt hold: 20 cycles checked");

    // Asynchronous reset in HALT
    #1 rst = 1'b0; ce = 1'b1;
    #1;
    chk13("rst_in_halt outs", outs, ZERO);
    chk16("rst_in_halt count", instr_count, 16'd0);
    $display("reset in HALT: halted=%0d count=%0d", halted, instr_count);

    // Asynchronous reset in EXE_UAL drops load_ACC at once
    @(posedge clk); #1;
    rst = 1'b1; code_op = 3'b001;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk13("exe_before_rst outs", outs, S_ADD);
    #1 rst = 1'b0;
    #1;
    chk13("exe_after_rst outs", outs, ZERO);
    $display("reset in EXE_UAL: load_ACC=%0d", load_ACC);

    // Counter wrap with CNT_W = 4: 16 LDA instructions
    @(posedge clk); #1;
    rst = 1'b1; code_op = 3'b101; ce = 1'b1;
    repeat (76) @(posedge clk);
    #1;
    chk16("wrap15 count", instr_count, 16'd15);
    chk16("wrap15 count_w4", {12'd0, w_instr_count}, 16'd15);
    repeat (5) @(posedge clk);
    #1;
    chk16("wrap16 count", instr_count, 16'd16);
    chk16("wrap16 count_w4", {12'd0, w_instr_count}, 16'd0);
    $display("wrap: count16=%0d count4=%0d", instr_count, w_instr_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
